regwrite_arbiter: RTL
=====================

REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: write data width, matching register32.
REQ-002 Parameter ADDR_WIDTH, default 5: register address width (32 registers).
REQ-003 clk  input  1  Single clock; all state updates on posedge.
REQ-004 reset  input  1  Reset, asynchronous and active-high.
REQ-005 req0 / req1  input  1 each  Write request from requester 0 / 1.
REQ-006 addr0 / addr1  input  ADDR_WIDTH each  Destination register of requester 0 / 1.
REQ-007 data0 / data1  input  DATA_WIDTH each  Write data of requester 0 / 1.
REQ-008 gnt0 / gnt1  output  1 each  Registered one-cycle grant pulse to requester 0 / 1.
REQ-009 wr_enable  output  1  Registered write enable to the register file (fans out to the register32 wrenable pins through the address decoder).
REQ-010 wr_addr  output  ADDR_WIDTH  Registered write address.
REQ-011 wr_data  output  DATA_WIDTH  Registered write data.
REQ-012 busy  output  1  High in any cycle where gnt0 or gnt1 is high.

Function
REQ-013 The FSM SHALL have two states: IDLE (no grant outstanding) and WRITE (one grant and write issued this cycle).
REQ-014 At each posedge, if req0 or req1 is high, FSM SHALL enter or stay in WRITE; otherwise it SHALL enter IDLE. Back-to-back WRITE cycles are allowed.
REQ-015 Latency: a request sampled at posedge N SHALL produce gnt and wr_* outputs valid during cycle N+1 (exactly 1 cycle).
REQ-016 At most one of gnt0, gnt1 SHALL be high in any cycle.
REQ-017 Arbitration SHALL be round-robin: a 1-bit last-grant register records the most recent winner; on simultaneous requests the other requester wins.
REQ-018 With a single request, that requester SHALL win regardless of last-grant.
REQ-019 On grant, wr_addr/wr_data SHALL capture the winner's addr/data; wr_enable SHALL be 1 unless the captured address is 0.
REQ-020 Address 0 is hard-wired zero: such a request SHALL still be granted, but wr_enable SHALL be 0 in that cycle.
REQ-021 In IDLE, wr_enable, gnt0 and gnt1 SHALL be 0; wr_addr/wr_data SHALL hold their last values.
REQ-022 A requester SHALL hold req/addr/data stable until it sees its gnt; if req is still high at the posedge ending the gnt cycle, that SHALL be arbitrated as a new request.
REQ-023 The losing requester's request SHALL remain pending and be granted no later than 2 cycles after it was first sampled.

Reset
REQ-024 Asserting reset SHALL immediately force: state IDLE, gnt0=gnt1=0, wr_enable=0, busy=0, wr_addr=0, wr_data=0, last-grant=1 (requester 0 wins the first tie).
REQ-025 Reset asserted during a WRITE cycle SHALL cancel that write asynchronously; the request is not retried unless req is still high after reset deasserts.

Configuration
REQ-026 Macro REGWRITE_ARBITER_LOCK_EN: when defined, inputs lock0/lock1 (1 bit each) SHALL exist; a requester granted with its lock high SHALL win the next cycle's arbitration even on a tie, for as long as it keeps req and lock high.
REQ-027 When REGWRITE_ARBITER_LOCK_EN is undefined, the lock ports SHALL not exist and arbitration SHALL be pure round-robin per REQ-017.

Verification
REQ-028 After reset, req0=1 addr0=7 data0=123456789 for one cycle -> next cycle gnt0=1, wr_enable=1, wr_addr=7, wr_data=123456789; then IDLE with all enables 0.
REQ-029 req0 and req1 both held high from reset release (addr0=3 data0=666666, addr1=4 data1=42) -> grants alternate gnt0, gnt1, gnt0, ... on consecutive cycles, wr_addr alternating 3, 4.
REQ-030 req1=1 addr1=0 data1=0xFFFFFFFF -> gnt1=1, wr_enable=0 in the grant cycle.
REQ-031 Reset pulsed asynchronously mid-cycle during a gnt0 pulse -> gnt0, wr_enable, wr_addr, wr_data drop to 0 before the next posedge; first grant after release on a tie goes to requester 0.
REQ-032 With REGWRITE_ARBITER_LOCK_EN: req0=lock0=1 and req1=1 held for 4 cycles -> gnt0 all 4 cycles; dropping lock0 -> gnt1 next grant cycle.

Source files
------------

// File: rtl/regwrite_arbiter.sv
// regwrite_arbiter: two-requester round-robin arbiter in front of the register
// file write port. One request per cycle is granted; grant and write outputs
// appear one cycle after the request is sampled.
//
// Optional feature macro: REGWRITE_ARBITER_LOCK_EN adds lock0/lock1 inputs.
// A requester granted with its lock high keeps winning ties for as long as
// it holds req and lock high.
//
// Ports:
//   clk            clock, all state updates on posedge
//   reset          asynchronous active-high reset
//   req0/req1      write requests
//   addr0/addr1    destination register of each requester
//   data0/data1    write data of each requester
//   lock0/lock1    (REGWRITE_ARBITER_LOCK_EN only) hold-arbitration request
//   gnt0/gnt1      registered one-cycle grant pulses
//   wr_enable      registered write enable (0 for address 0)
//   wr_addr        registered write address
//   wr_data        registered write data
//   busy           high in any cycle where a grant is high
module regwrite_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
`ifdef REGWRITE_ARBITER_LOCK_EN
    input  logic                  lock0,
    input  logic                  lock1,
`endif
    input  logic                  req0,
    input  logic                  req1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] data0,
    input  logic [DATA_WIDTH-1:0] data1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  wr_enable,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;     // most recent winner: 1 = requester 1
    logic                    gnt0_q, gnt0_d;
    logic                    gnt1_q, gnt1_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    win;                // this cycle's winner: 1 = requester 1
`ifdef REGWRITE_ARBITER_LOCK_EN
    logic                    lock_q, lock_d;     // last grant was taken with lock high
`endif

    // Next-state, arbitration and write-port capture.
    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        win     = 1'b0;
`ifdef REGWRITE_ARBITER_LOCK_EN
        lock_d  = 1'b0;
`endif

        if (req0 && req1) begin
            win = ~last_q;
`ifdef REGWRITE_ARBITER_LOCK_EN
            // Locked owner keeps the port while it still holds its lock.
            if (lock_q && (last_q ? lock1 : lock0)) begin
                win = last_q;
            end
`endif
        end else begin
            win = req1;
        end

        if (req0 || req1) begin
            state_d = WRITE;
            last_d  = win;
            gnt0_d  = ~win;
            gnt1_d  = win;
            addr_d  = win ? addr1 : addr0;
            data_d  = win ? data1 : data0;
            // Register 0 is hard-wired zero: grant it but never write it.
            we_d    = (addr_d != ADDR_WIDTH'(0));
`ifdef REGWRITE_ARBITER_LOCK_EN
            lock_d  = win ? lock1 : lock0;
`endif
        end
    end

    // State and output registers; reset cancels any in-flight write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef REGWRITE_ARBITER_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef REGWRITE_ARBITER_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign gnt0      = gnt0_q;
    assign gnt1      = gnt1_q;
    assign wr_enable = we_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    // A grant is high exactly in WRITE cycles.
    assign busy      = (state_q == WRITE);

endmodule
